// File: rtl/ctrl_pkg.sv
// Shared encodings for the hardwired accumulator-CPU control unit:
// bus sources, ALU operations, opcodes and register-reference bit positions.
package ctrl_pkg;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_MEM  = 3'd6
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_NOP     = 3'd0,
    ALU_AND     = 3'd1,
    ALU_ADD     = 3'd2,
    ALU_PASS_DR = 3'd3,
    ALU_CLR     = 3'd4,
    ALU_CMA     = 3'd5,
    ALU_INC     = 3'd6
  } alu_op_e;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  // Bit positions within the address field for register-reference instructions
  localparam int RR_CLA = 11;
  localparam int RR_CMA = 9;
  localparam int RR_INC = 5;
  localparam int RR_SPA = 4;
  localparam int RR_SNA = 3;
  localparam int RR_SZA = 2;
  localparam int RR_HLT = 0;

  localparam int T_W    = 8;
  localparam int STEP_W = 3;

endpackage

// File: rtl/ctrl_sequencer_timing_check.sv
// One-hot validator for the SC timing word; reports validity and the
// binary index of the active step.
module timing_check
  import ctrl_pkg::*;
(
  input  logic [T_W-1:0]    t_in,
  output logic              t_valid,
  output logic [STEP_W-1:0] step
);

  assign t_valid = $onehot(t_in);

  always_comb begin
    step = '0;
    for (int k = 0; k < T_W; k++) begin
      if (t_in[k]) step = STEP_W'(k);
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired control unit: decodes SC timing word, latched opcode and IR into
// datapath strobes; tracks halt and malformed-timing conditions.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [T_W-1:0]    t_in,
  input  logic [DATA_W-1:0] ir,
  input  logic              dr_zero,
  input  logic              ac_zero,
  input  logic              ac_neg,
  output logic [2:0]        bus_sel,
  output logic              ar_ld,
  output logic              ar_inc,
  output logic              pc_ld,
  output logic              pc_inc,
  output logic              ir_ld,
  output logic              dr_ld,
  output logic              dr_inc,
  output logic              ac_ld,
  output logic [2:0]        alu_op,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              sc_clr,
  output logic              sc_en,
  output logic              halted,
  output logic              t_err
);

  logic              t_valid;
  logic [STEP_W-1:0] step;
  logic [2:0]        d_q, d_d;
  logic              i_q, i_d;
  logic              halted_q, halted_d;
  logic              t_err_q, t_err_d;
  logic [ADDR_W-1:0] rr;
  logic [2:0]        opcode;
  logic              ind_bit;
  logic              d7;
  logic              active;
  logic              unused_rr;

  timing_check u_timing_check (
    .t_in    (t_in),
    .t_valid (t_valid),
    .step    (step)
  );

  assign rr        = ir[ADDR_W-1:0];
  assign opcode    = ir[DATA_W-2:DATA_W-4];
  assign ind_bit   = ir[DATA_W-1];
  assign d7        = (d_q == OP_REG);
  assign unused_rr = ^{rr[10], rr[8:6], rr[1]};

  // Halt freezes everything; reset input gates strobes combinationally so
  // they drop the instant rst falls, not at the next edge.
  assign active = rst & t_valid & ~halted_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q      <= '0;
      i_q      <= 1'b0;
      halted_q <= 1'b0;
      t_err_q  <= 1'b0;
    end else begin
      d_q      <= d_d;
      i_q      <= i_d;
      halted_q <= halted_d;
      t_err_q  <= t_err_d;
    end
  end

  always_comb begin
    d_d      = d_q;
    i_d      = i_q;
    halted_d = halted_q;
    t_err_d  = t_err_q;
    if (!t_valid) begin
      t_err_d = 1'b1;
    end else if (!halted_q) begin
      if (step == 3'd2) begin
        d_d = opcode;
        i_d = ind_bit;
      end
      if (step == 3'd3 && d7 && !i_q && rr[RR_HLT]) halted_d = 1'b1;
    end
  end

  always_comb begin
    bus_sel = BUS_NONE;
    alu_op  = ALU_NOP;
    ar_ld   = 1'b0;
    ar_inc  = 1'b0;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    ir_ld   = 1'b0;
    dr_ld   = 1'b0;
    dr_inc  = 1'b0;
    ac_ld   = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    sc_clr  = 1'b0;
    if (active) begin
      case (step)
        3'd0: begin
          bus_sel = BUS_PC;
          ar_ld   = 1'b1;
        end
        3'd1: begin
          bus_sel = BUS_MEM;
          mem_rd  = 1'b1;
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
        end
        3'd2: begin
          bus_sel = BUS_IR;
          ar_ld   = 1'b1;
        end
        3'd3: begin
          if (d7) begin
            sc_clr = 1'b1;
            if (!i_q) begin
              if (rr[RR_CLA])      alu_op = ALU_CLR;
              else if (rr[RR_CMA]) alu_op = ALU_CMA;
              else if (rr[RR_INC]) alu_op = ALU_INC;
              ac_ld  = rr[RR_CLA] | rr[RR_CMA] | rr[RR_INC];
              pc_inc = (rr[RR_SPA] & ~ac_neg & ~ac_zero)
                     | (rr[RR_SNA] & ac_neg)
                     | (rr[RR_SZA] & ac_zero);
            end
          end else if (i_q) begin
            bus_sel = BUS_MEM;
            mem_rd  = 1'b1;
            ar_ld   = 1'b1;
          end
        end
        3'd4: begin
          if (!d7) begin
            case (d_q)
              OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                bus_sel = BUS_MEM;
                mem_rd  = 1'b1;
                dr_ld   = 1'b1;
              end
              OP_STA: begin
                bus_sel = BUS_AC;
                mem_wr  = 1'b1;
                sc_clr  = 1'b1;
              end
              OP_BUN: begin
                bus_sel = BUS_AR;
                pc_ld   = 1'b1;
                sc_clr  = 1'b1;
              end
              OP_BSA: begin
                bus_sel = BUS_PC;
                mem_wr  = 1'b1;
                ar_inc  = 1'b1;
              end
              default: ;
            endcase
          end
        end
        3'd5: begin
          if (!d7) begin
            case (d_q)
              OP_AND: begin alu_op = ALU_AND;     ac_ld = 1'b1; sc_clr = 1'b1; end
              OP_ADD: begin alu_op = ALU_ADD;     ac_ld = 1'b1; sc_clr = 1'b1; end
              OP_LDA: begin alu_op = ALU_PASS_DR; ac_ld = 1'b1; sc_clr = 1'b1; end
              OP_BSA: begin
                bus_sel = BUS_AR;
                pc_ld   = 1'b1;
                sc_clr  = 1'b1;
              end
              OP_ISZ: dr_inc = 1'b1;
              default: ;
            endcase
          end
        end
        3'd6: begin
          if (!d7 && d_q == OP_ISZ) begin
            bus_sel = BUS_DR;
            mem_wr  = 1'b1;
            pc_inc  = dr_zero;
            sc_clr  = 1'b1;
          end
        end
        // T7 is unreachable in a correct program; clear SC to recover
        default: sc_clr = 1'b1;
      endcase
    end
  end

  assign sc_en  = rst & ~halted_q;
  assign halted = halted_q;
  assign t_err  = t_err_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed instruction walks, an instruction-level
// reference model compared every cycle, and literal spot checks.
module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  t_in;
  logic [15:0] ir;
  logic        dr_zero, ac_zero, ac_neg;
  logic [2:0]  bus_sel, alu_op;
  logic        ar_ld, ar_inc, pc_ld, pc_inc, ir_ld, dr_ld, dr_inc, ac_ld;
  logic        mem_rd, mem_wr, sc_clr, sc_en, halted, t_err;

  int n_chk = 0;
  int n_err = 0;

  ctrl_sequencer #(.DATA_W(16), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .t_in(t_in), .ir(ir),
    .dr_zero(dr_zero), .ac_zero(ac_zero), .ac_neg(ac_neg),
    .bus_sel(bus_sel), .ar_ld(ar_ld), .ar_inc(ar_inc), .pc_ld(pc_ld),
    .pc_inc(pc_inc), .ir_ld(ir_ld), .dr_ld(dr_ld), .dr_inc(dr_inc),
    .ac_ld(ac_ld), .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .sc_clr(sc_clr), .sc_en(sc_en), .halted(halted), .t_err(t_err)
  );

  always #5 clk = ~clk;

  logic [19:0] dut_vec;
  assign dut_vec = {bus_sel, ar_ld, ar_inc, pc_ld, pc_inc, ir_ld, dr_ld, dr_inc,
                    ac_ld, alu_op, mem_rd, mem_wr, sc_clr, sc_en, halted, t_err};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction-level view of what each timing step must do.
  logic [2:0] m_d = 3'd0;
  logic       m_i = 1'b0, m_h = 1'b0, m_te = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_d <= 3'd0; m_i <= 1'b0; m_h <= 1'b0; m_te <= 1'b0;
    end else if ($countones(t_in) != 1) begin
      m_te <= 1'b1;
    end else if (!m_h) begin
      if (t_in == 8'h04) begin m_d <= ir[14:12]; m_i <= ir[15]; end
      if (t_in == 8'h08 && m_d == 3'd7 && !m_i && ir[0]) m_h <= 1'b1;
    end
  end

  function automatic logic [19:0] model_out(
    input logic r, input logic [7:0] t, input logic [2:0] d, input logic i,
    input logic h, input logic te, input logic [15:0] iv,
    input logic dz, input logic az, input logic an);
    logic [2:0] bus, alu;
    logic arl, ari, pcl, pci, irl, drl, dri, acl, mr, mw, clr;
    int k;
    bus = 3'd0; alu = 3'd0;
    {arl, ari, pcl, pci, irl, drl, dri, acl, mr, mw, clr} = '0;
    k = -1;
    if ($countones(t) == 1)
      for (int j = 0; j < 8; j++) if (t[j]) k = j;
    if (r && !h && k >= 0) begin
      if (k == 0) begin bus = 3'd2; arl = 1; end
      else if (k == 1) begin bus = 3'd6; mr = 1; irl = 1; pci = 1; end
      else if (k == 2) begin bus = 3'd5; arl = 1; end
      else if (k == 7) clr = 1;
      else if (d == 3'd7) begin
        if (k == 3) begin
          clr = 1;
          if (!i) begin
            if (iv[11]) alu = 3'd4; else if (iv[9]) alu = 3'd5; else if (iv[5]) alu = 3'd6;
            acl = iv[11] | iv[9] | iv[5];
            pci = (iv[4] & ~an & ~az) | (iv[3] & an) | (iv[2] & az);
          end
        end
      end else if (k == 3) begin
        if (i) begin bus = 3'd6; mr = 1; arl = 1; end
      end else begin
        case (d)
          3'd0, 3'd1, 3'd2:
            if (k == 4) begin bus = 3'd6; mr = 1; drl = 1; end
            else if (k == 5) begin alu = d + 3'd1; acl = 1; clr = 1; end
          3'd3: if (k == 4) begin bus = 3'd4; mw = 1; clr = 1; end
          3'd4: if (k == 4) begin bus = 3'd1; pcl = 1; clr = 1; end
          3'd5:
            if (k == 4) begin bus = 3'd2; mw = 1; ari = 1; end
            else if (k == 5) begin bus = 3'd1; pcl = 1; clr = 1; end
          default:
            if (k == 4) begin bus = 3'd6; mr = 1; drl = 1; end
            else if (k == 5) dri = 1;
            else if (k == 6) begin bus = 3'd3; mw = 1; pci = dz; clr = 1; end
        endcase
      end
    end
    return {bus, arl, ari, pcl, pci, irl, drl, dri, acl, alu, mr, mw, clr,
            r & ~h, h, te};
  endfunction

  always @(negedge clk)
    chk("model", {12'd0, dut_vec},
        {12'd0, model_out(rst, t_in, m_d, m_i, m_h, m_te, ir, dr_zero, ac_zero, ac_neg)});

  task automatic tick(input logic [7:0] t);
    @(posedge clk);
    #1 t_in = t;
  endtask

  task automatic fetch(input logic [15:0] v);
    tick(8'h01);
    ir = v;
    tick(8'h02);
    tick(8'h04);
  endtask

  initial begin
    rst = 1'b0; t_in = 8'h01; ir = 16'h0000;
    dr_zero = 1'b0; ac_zero = 1'b0; ac_neg = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_bus", bus_sel, 0);
    chk("rst_arld", ar_ld, 0);
    chk("rst_halt", halted, 0);
    chk("rst_terr", t_err, 0);

    // Release with T0 then T1
    @(posedge clk);
    #1 rst = 1'b1; t_in = 8'h01;
    #2 chk("t0_bus", bus_sel, 2); chk("t0_arld", ar_ld, 1); chk("t0_scen", sc_en, 1);
    tick(8'h02);
    #2 chk("t1_bus", bus_sel, 6); chk("t1_rd", mem_rd, 1); chk("t1_irld", ir_ld, 1);
    chk("t1_pcinc", pc_inc, 1); chk("t1_halt", halted, 0);
    tick(8'h04); tick(8'h08); tick(8'h10); tick(8'h20);
    #2 chk("and_alu", alu_op, 1);

    // ADD direct
    fetch(16'h1ABC);
    #2 chk("add_t2_bus", bus_sel, 5); chk("add_t2_arld", ar_ld, 1);
    tick(8'h08);
    #2 chk("add_t3_none", dut_vec[19:3], 0);
    tick(8'h10);
    #2 chk("add_t4_bus", bus_sel, 6); chk("add_t4_rd", mem_rd, 1); chk("add_t4_drld", dr_ld, 1);
    tick(8'h20);
    #2 chk("add_t5_alu", alu_op, 2); chk("add_t5_acld", ac_ld, 1); chk("add_t5_clr", sc_clr, 1);

    // LDA indirect
    fetch(16'hA123);
    tick(8'h08);
    #2 chk("ind_bus", bus_sel, 6); chk("ind_rd", mem_rd, 1); chk("ind_arld", ar_ld, 1);
    tick(8'h10); tick(8'h20);
    #2 chk("lda_alu", alu_op, 3); chk("lda_acld", ac_ld, 1); chk("lda_clr", sc_clr, 1);

    // ISZ with and without a zero result
    for (int n = 0; n < 2; n++) begin
      dr_zero = (n == 0);
      fetch(16'h6040);
      tick(8'h08); tick(8'h10); tick(8'h20);
      #2 chk("isz_dri", dr_inc, 1);
      tick(8'h40);
      #2 chk("isz_bus", bus_sel, 3); chk("isz_wr", mem_wr, 1);
      chk("isz_pcinc", pc_inc, (n == 0) ? 1 : 0); chk("isz_clr", sc_clr, 1);
    end

    // Register reference: CLA beats CMA; SZA skip
    fetch(16'h7A00);
    tick(8'h08);
    #2 chk("cla_alu", alu_op, 4); chk("cla_acld", ac_ld, 1); chk("cla_clr", sc_clr, 1);
    ac_zero = 1'b1;
    fetch(16'h7004);
    tick(8'h08);
    #2 chk("sza_pcinc", pc_inc, 1); chk("sza_acld", ac_ld, 0);
    ac_zero = 1'b0;
    fetch(16'h7010);
    tick(8'h08);
    #2 chk("spa_pcinc", pc_inc, 1);

    // BSA, BUN, I/O, stray T7
    fetch(16'h5010);
    tick(8'h08); tick(8'h10);
    #2 chk("bsa_t4_bus", bus_sel, 2); chk("bsa_t4_wr", mem_wr, 1); chk("bsa_t4_arinc", ar_inc, 1);
    tick(8'h20);
    #2 chk("bsa_t5_bus", bus_sel, 1); chk("bsa_t5_pcld", pc_ld, 1);
    fetch(16'h4020);
    tick(8'h08); tick(8'h10);
    #2 chk("bun_pcld", pc_ld, 1); chk("bun_bus", bus_sel, 1);
    fetch(16'hF800);
    tick(8'h08);
    #2 chk("io_clr", sc_clr, 1); chk("io_bus", bus_sel, 0);
    tick(8'h80);
    #2 chk("t7_clr", sc_clr, 1);

    // HLT
    fetch(16'h7001);
    tick(8'h08);
    #2 chk("hlt_clr", sc_clr, 1); chk("hlt_pre", halted, 0);
    tick(8'h01);
    #2 chk("hlt_halted", halted, 1); chk("hlt_scen", sc_en, 0); chk("hlt_quiet", dut_vec[19:3], 0);
    tick(8'h02);
    #2 chk("hlt_hold", halted, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("hlt_rstclr", halted, 0);
    @(posedge clk);
    #1 rst = 1'b1; t_in = 8'h01;
    #2 chk("rel_bus", bus_sel, 2);

    // Malformed timing word, then reset mid-STA
    tick(8'h03);
    #2 chk("terr_quiet", dut_vec[19:3], 0); chk("terr_pre", t_err, 0);
    tick(8'h00);
    #2 chk("terr_set", t_err, 1);
    fetch(16'h3050);
    #2 chk("terr_sticky", t_err, 1);
    tick(8'h08); tick(8'h10);
    #2 chk("sta_wr", mem_wr, 1); chk("sta_bus", bus_sel, 4); chk("sta_clr", sc_clr, 1);
    #1 rst = 1'b0;
    #1 chk("sta_rst_wr", mem_wr, 0); chk("sta_rst_terr", t_err, 0); chk("sta_rst_bus", bus_sel, 0);
    @(posedge clk);
    #1 rst = 1'b1; t_in = 8'h01;
    #2 chk("final_bus", bus_sel, 2); chk("final_arld", ar_ld, 1);
    tick(8'h02);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
